// File: rtl/csoc_scan_chains.sv
// Multi-chain scan emulator: NCHAINS chains of CHAIN_LEN flops with functional,
// capture and shift modes, a per-pass shift counter and a pass-complete pulse.
module csoc_scan_chains #(
    parameter int NCHAINS   = 4,
    parameter int CHAIN_LEN = 480,
    parameter int DW        = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DW-1:0]                data_i,
    output logic [DW-1:0]                data_o,
    input  logic                         test_tm_i,
    input  logic                         test_se_i,
    input  logic [NCHAINS-1:0]           scan_in_i,
    output logic [NCHAINS-1:0]           scan_out_o,
    output logic [1:0]                   mode_o,
    output logic [$clog2(CHAIN_LEN)-1:0] shift_cnt_o,
    output logic                         chain_done_o
);

    localparam int CW = $clog2(CHAIN_LEN);

    localparam logic [1:0] MODE_FUNC  = 2'd0;
    localparam logic [1:0] MODE_CAPT  = 2'd1;
    localparam logic [1:0] MODE_SHIFT = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);

    logic                 r_tm;
    logic                 r_se;
    logic [NCHAINS-1:0]   r_si;
    logic [DW-1:0]        r_d;

    logic [CHAIN_LEN-1:0] r_chain [NCHAINS];
    logic [CHAIN_LEN-1:0] w_chain_nxt [NCHAINS];

    logic [DW-1:0]        r_data;
    logic [CW-1:0]        r_cnt;
    logic                 r_done;

    logic [1:0]           w_mode;
    logic [DW-1:0]        w_data_nxt;
    logic [CW-1:0]        w_cnt_nxt;
    logic                 w_done_nxt;
    logic                 w_unused_d;

    // Data bits beyond the chain count never feed a chain.
    assign w_unused_d = ^r_d;

    // Input stage: every pin is registered once before it touches the chains.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tm <= 1'b0;
            r_se <= 1'b0;
            r_si <= {NCHAINS{1'b0}};
            r_d  <= {DW{1'b0}};
        end else begin
            r_tm <= test_tm_i;
            r_se <= test_se_i;
            r_si <= scan_in_i;
            r_d  <= data_i;
        end
    end

    // Mode decode from the registered test pins.
    always_comb begin
        w_mode = MODE_FUNC;
        if (r_tm) begin
            if (r_se) begin
                w_mode = MODE_SHIFT;
            end else begin
                w_mode = MODE_CAPT;
            end
        end else begin
            w_mode = MODE_FUNC;
        end
    end

    // Next chain contents: serial shift, or rotate with functional data injected at bit 0.
    always_comb begin
        for (int c = 0; c < NCHAINS; c++) begin
            w_chain_nxt[c] = r_chain[c];
            if (w_mode == MODE_SHIFT) begin
                w_chain_nxt[c] = {r_chain[c][CHAIN_LEN-2:0], r_si[c]};
            end else begin
                w_chain_nxt[c] = {r_chain[c][CHAIN_LEN-2:0],
                                  r_chain[c][CHAIN_LEN-1] ^ r_d[c % DW]};
            end
        end
    end

    // Chain flops; mode changes never clear them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NCHAINS; c++) begin
                r_chain[c] <= {CHAIN_LEN{1'b0}};
            end
        end else begin
            for (int c = 0; c < NCHAINS; c++) begin
                r_chain[c] <= w_chain_nxt[c];
            end
        end
    end

    // Output-side next state: functional readout, pass counter and wrap detect.
    always_comb begin
        w_data_nxt = r_data;
        w_cnt_nxt  = {CW{1'b0}};
        w_done_nxt = 1'b0;
        case (w_mode)
            MODE_FUNC: begin
                w_data_nxt = r_chain[0][CHAIN_LEN-1 -: DW];
            end
            MODE_CAPT: begin
                w_data_nxt = r_data;
            end
            MODE_SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt  = {CW{1'b0}};
                    w_done_nxt = 1'b1;
                end else begin
                    w_cnt_nxt  = r_cnt + CW'(1);
                    w_done_nxt = 1'b0;
                end
            end
            default: begin
                w_data_nxt = r_data;
                w_cnt_nxt  = {CW{1'b0}};
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Registered functional data, shift counter and pass-complete pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data <= {DW{1'b0}};
            r_cnt  <= {CW{1'b0}};
            r_done <= 1'b0;
        end else begin
            r_data <= w_data_nxt;
            r_cnt  <= w_cnt_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Serial outputs come straight from the last flop of each chain.
    always_comb begin
        scan_out_o = {NCHAINS{1'b0}};
        for (int c = 0; c < NCHAINS; c++) begin
            scan_out_o[c] = r_chain[c][CHAIN_LEN-1];
        end
    end

    assign data_o       = r_data;
    assign mode_o       = w_mode;
    assign shift_cnt_o  = r_cnt;
    assign chain_done_o = r_done;

endmodule

// File: tb/tb_csoc_scan_chains.sv
// Directed bench for csoc_scan_chains with NCHAINS=2, CHAIN_LEN=8, DW=8.
module tb_csoc_scan_chains;

    localparam int NCHAINS   = 2;
    localparam int CHAIN_LEN = 8;
    localparam int DW        = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [7:0]   data_i;
    logic [7:0]   data_o;
    logic         test_tm_i;
    logic         test_se_i;
    logic [1:0]   scan_in_i;
    logic [1:0]   scan_out_o;
    logic [1:0]   mode_o;
    logic [2:0]   shift_cnt_o;
    logic         chain_done_o;

    int vectors     = 0;
    int miscompares = 0;
    int pulses;

    csoc_scan_chains #(
        .NCHAINS   (NCHAINS),
        .CHAIN_LEN (CHAIN_LEN),
        .DW        (DW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .data_o       (data_o),
        .test_tm_i    (test_tm_i),
        .test_se_i    (test_se_i),
        .scan_in_i    (scan_in_i),
        .scan_out_o   (scan_out_o),
        .mode_o       (mode_o),
        .shift_cnt_o  (shift_cnt_o),
        .chain_done_o (chain_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset with random pins
        rst_i     = 1'b1;
        data_i    = 8'($urandom);
        test_tm_i = 1'($urandom);
        test_se_i = 1'($urandom);
        scan_in_i = 2'($urandom);
        tick();
        data_i    = 8'($urandom);
        scan_in_i = 2'($urandom);
        tick();
        chk("rst_scan_out", 32'(scan_out_o), 32'h0);
        chk("rst_data_o", 32'(data_o), 32'h0);
        chk("rst_mode", 32'(mode_o), 32'h0);
        chk("rst_cnt", 32'(shift_cnt_o), 32'h0);
        chk("rst_done", 32'(chain_done_o), 32'h0);

        rst_i = 1'b0; data_i = 8'h00; test_tm_i = 1'b0; test_se_i = 1'b0; scan_in_i = 2'b00;
        tick();

        // 2: flush a single 1 through chain 0
        test_tm_i = 1'b1; test_se_i = 1'b1;
        tick();
        chk("flush_mode", 32'(mode_o), 32'h2);
        scan_in_i = 2'b01;
        tick();
        scan_in_i = 2'b00;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("flush_out_k%0d", k), 32'(scan_out_o), (k == 8) ? 32'h1 : 32'h0);
        end

        // leave shift so the counter clears
        test_tm_i = 1'b0;
        tick();
        tick();
        chk("func_cnt_clear", 32'(shift_cnt_o), 32'h0);
        chk("func_mode", 32'(mode_o), 32'h0);

        // 3: three back-to-back passes
        test_tm_i = 1'b1; test_se_i = 1'b1;
        tick();
        chk("pass_cnt_start", 32'(shift_cnt_o), 32'h0);
        chk("pass_done_start", 32'(chain_done_o), 32'h0);
        pulses = 0;
        for (int j = 1; j <= 24; j++) begin
            tick();
            chk($sformatf("pass_cnt_j%0d", j), 32'(shift_cnt_o), 32'(j % 8));
            chk($sformatf("pass_done_j%0d", j), 32'(chain_done_o), (j % 8 == 0) ? 32'h1 : 32'h0);
            if (chain_done_o) pulses++;
        end
        chk("pass_pulse_count", 32'(pulses), 32'd3);

        // 4: load chain0 = 8'h01, then capture with zero data rotates it home
        scan_in_i = 2'b01;
        tick();
        scan_in_i = 2'b00; test_se_i = 1'b0;
        tick();
        chk("capt_mode", 32'(mode_o), 32'h1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("capt_out_k%0d", k), 32'(scan_out_o), (k == 7) ? 32'h1 : 32'h0);
        end
        chk("capt_cnt", 32'(shift_cnt_o), 32'h0);
        chk("capt_data_hold0", 32'(data_o), 32'h0);
        // inject data_i[0]=1 for one capture cycle: 01 -> 02 -> 05 -> 0A
        data_i = 8'h01;
        tick();
        data_i = 8'h00;
        tick();
        test_tm_i = 1'b0;
        tick();
        tick();
        chk("capt_toggle_readout", 32'(data_o), 32'h0A);
        tick();
        chk("func_readout_next", 32'(data_o), 32'h14);
        test_tm_i = 1'b1;
        tick();
        tick();
        chk("capt_data_hold", 32'(data_o), 32'h28);
        chk("capt_mode2", 32'(mode_o), 32'h1);

        // 5: abort a pass after 5 shifts, then restart (chain0 A0 -> 41 on entry)
        test_se_i = 1'b1;
        tick();
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk($sformatf("abort_cnt_j%0d", j), 32'(shift_cnt_o), 32'(j));
        end
        test_se_i = 1'b0;
        tick();
        chk("abort_cnt5", 32'(shift_cnt_o), 32'h5);
        tick();
        chk("abort_cnt_cleared", 32'(shift_cnt_o), 32'h0);
        chk("abort_no_done", 32'(chain_done_o), 32'h0);
        test_se_i = 1'b1;
        tick();
        chk("reentry_cnt", 32'(shift_cnt_o), 32'h0);
        chk("reentry_bits_kept", 32'(scan_out_o), 32'h1);
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk($sformatf("reentry_cnt_j%0d", j), 32'(shift_cnt_o), 32'(j % 8));
            chk($sformatf("reentry_done_j%0d", j), 32'(chain_done_o), (j == 8) ? 32'h1 : 32'h0);
            if (j == 1) chk("reentry_out_j1", 32'(scan_out_o), 32'h0);
        end

        // 6: reset in the middle of a pass
        scan_in_i = 2'b11;
        for (int k = 1; k <= 6; k++) tick();
        chk("mid_cnt6", 32'(shift_cnt_o), 32'h6);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; scan_in_i = 2'b00;
        chk("mid_rst_cnt", 32'(shift_cnt_o), 32'h0);
        chk("mid_rst_done", 32'(chain_done_o), 32'h0);
        chk("mid_rst_data", 32'(data_o), 32'h0);
        chk("mid_rst_mode", 32'(mode_o), 32'h0);
        chk("mid_rst_out", 32'(scan_out_o), 32'h0);
        tick();
        chk("mid_post_done", 32'(chain_done_o), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("mid_flush_k%0d", k), 32'(scan_out_o), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
